// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: stall/flush/forward control for a 5-stage pipeline with a multicycle divide FSM.
// Define HAZARD_FWD_EN for EX-stage forwarding; otherwise RAW hazards stall.
module hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DIV_LAT  = 8,
    parameter int CNT_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [ADDR_W-1:0] id_rs1_addr_i,
    input  logic [ADDR_W-1:0] id_rs2_addr_i,
    input  logic [ADDR_W-1:0] ex_rs1_addr_i,
    input  logic [ADDR_W-1:0] ex_rs2_addr_i,
    input  logic [ADDR_W-1:0] ex_rd_addr_i,
    input  logic              ex_reg_we_i,
    input  logic              ex_mem_read_i,
    input  logic              ex_div_start_i,
    input  logic [ADDR_W-1:0] mem_rd_addr_i,
    input  logic              mem_reg_we_i,
    input  logic              mem_req_i,
    input  logic              dmem_ack_i,
    input  logic [ADDR_W-1:0] wb_rd_addr_i,
    input  logic              wb_reg_we_i,
    input  logic              pc_src_e_i,
    output logic              stall_f_o,
    output logic              stall_d_o,
    output logic              stall_e_o,
    output logic              stall_m_o,
    output logic              flush_d_o,
    output logic              flush_e_o,
    output logic              flush_m_o,
    output logic              flush_w_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic              div_done_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);
    localparam int DW = $clog2(DIV_LAT);
    typedef enum logic [1:0] {IDLE, DIV_BUSY, DIV_DONE} state_t;
    state_t state, state_nx;
    logic [DW-1:0] cnt, cnt_nx;
    logic [CNT_W-1:0] stall_cnt;
    logic mem_wait, hz, div_stall, cnt_zero;
    assign mem_wait = mem_req_i && !dmem_ack_i;
    assign cnt_zero = cnt == '0;
`ifdef HAZARD_FWD_EN
    logic unused_sig;
    assign unused_sig = ^{ex_reg_we_i, 1'(ADDR_W == $clog2(NUM_REGS))};
    assign fwd_a_o = (mem_reg_we_i && mem_rd_addr_i != '0 && mem_rd_addr_i == ex_rs1_addr_i) ? 2'b10 :
                     (wb_reg_we_i && wb_rd_addr_i != '0 && wb_rd_addr_i == ex_rs1_addr_i) ? 2'b01 : 2'b00;
    assign fwd_b_o = (mem_reg_we_i && mem_rd_addr_i != '0 && mem_rd_addr_i == ex_rs2_addr_i) ? 2'b10 :
                     (wb_reg_we_i && wb_rd_addr_i != '0 && wb_rd_addr_i == ex_rs2_addr_i) ? 2'b01 : 2'b00;
    assign hz = ex_mem_read_i && ex_rd_addr_i != '0 &&
                (ex_rd_addr_i == id_rs1_addr_i || ex_rd_addr_i == id_rs2_addr_i);
`else
    logic unused_sig, raw1, raw2;
    assign unused_sig = ^{ex_rs1_addr_i, ex_rs2_addr_i, ex_mem_read_i, 1'(ADDR_W == $clog2(NUM_REGS))};
    assign fwd_a_o = 2'b00;
    assign fwd_b_o = 2'b00;
    // Without forwarding, any in-flight writer of an ID source is a hazard
    assign raw1 = id_rs1_addr_i != '0 && ((ex_reg_we_i && ex_rd_addr_i == id_rs1_addr_i) ||
                  (mem_reg_we_i && mem_rd_addr_i == id_rs1_addr_i) || (wb_reg_we_i && wb_rd_addr_i == id_rs1_addr_i));
    assign raw2 = id_rs2_addr_i != '0 && ((ex_reg_we_i && ex_rd_addr_i == id_rs2_addr_i) ||
                  (mem_reg_we_i && mem_rd_addr_i == id_rs2_addr_i) || (wb_reg_we_i && wb_rd_addr_i == id_rs2_addr_i));
    assign hz = raw1 || raw2;
`endif
    assign div_stall = (state == IDLE && ex_div_start_i) || (state == DIV_BUSY && !cnt_zero);
    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        case (state)
            IDLE: begin
                state_nx = ex_div_start_i ? DIV_BUSY : IDLE;
                cnt_nx = ex_div_start_i ? DW'(DIV_LAT - 2) : cnt;
            end
            DIV_BUSY: begin
                cnt_nx = cnt_zero ? cnt : cnt - DW'(1);
                state_nx = !cnt_zero ? DIV_BUSY : mem_wait ? DIV_DONE : IDLE;
            end
            DIV_DONE: state_nx = mem_wait ? DIV_DONE : IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            cnt <= '0;
            stall_cnt <= '0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            stall_cnt <= stall_cnt + CNT_W'(stall_f_o);
        end
    end
    // A taken branch discards the hazarding ID instruction, so it overrides the hazard stall
    assign flush_d_o   = pc_src_e_i && !mem_wait && state != DIV_BUSY;
    assign stall_f_o   = mem_wait || div_stall || (hz && !flush_d_o);
    assign stall_d_o   = stall_f_o;
    assign stall_e_o   = mem_wait || div_stall;
    assign stall_m_o   = mem_wait;
    assign flush_e_o   = hz || flush_d_o;
    assign flush_m_o   = div_stall;
    assign flush_w_o   = mem_wait;
    assign div_done_o  = !mem_wait && ((state == DIV_BUSY && cnt_zero) || state == DIV_DONE);
    assign busy_o      = state != IDLE;
    assign stall_cnt_o = stall_cnt;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenarios plus random traffic against a cycle-age reference model.
module tb_hazard_scoreboard;
    localparam int DL = 8;
    logic clk = 0, rst_n = 0;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic ex_we, ex_mem_read, div_start, mem_we, mem_req, dmem_ack, wb_we, pc_src;
    logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w, div_done, busy;
    logic [1:0] fwd_a, fwd_b;
    logic [31:0] stall_cnt;
    int tests = 0, fails = 0, cyc = 0;
    bit m_act;
    int m_age;
    logic [31:0] m_cnt;
    logic e_sf, e_se, e_fd, e_fe, e_fm, e_done, mw, hz, dstall;
    logic [1:0] e_fa, e_fb;

    always #5 clk = ~clk;

    hazard_scoreboard #(.DIV_LAT(DL)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .id_rs1_addr_i(id_rs1), .id_rs2_addr_i(id_rs2),
        .ex_rs1_addr_i(ex_rs1), .ex_rs2_addr_i(ex_rs2), .ex_rd_addr_i(ex_rd),
        .ex_reg_we_i(ex_we), .ex_mem_read_i(ex_mem_read), .ex_div_start_i(div_start),
        .mem_rd_addr_i(mem_rd), .mem_reg_we_i(mem_we), .mem_req_i(mem_req), .dmem_ack_i(dmem_ack),
        .wb_rd_addr_i(wb_rd), .wb_reg_we_i(wb_we), .pc_src_e_i(pc_src),
        .stall_f_o(stall_f), .stall_d_o(stall_d), .stall_e_o(stall_e), .stall_m_o(stall_m),
        .flush_d_o(flush_d), .flush_e_o(flush_e), .flush_m_o(flush_m), .flush_w_o(flush_w),
        .fwd_a_o(fwd_a), .fwd_b_o(fwd_b), .div_done_o(div_done), .busy_o(busy),
        .stall_cnt_o(stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic idle();
        {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
        {ex_we, ex_mem_read, div_start, mem_we, mem_req, dmem_ack, wb_we, pc_src} = '0;
    endtask

    function automatic logic [1:0] fwd_model(input logic [4:0] s);
        if (mem_we && mem_rd != 0 && mem_rd == s) return 2'b10;
        if (wb_we && wb_rd != 0 && wb_rd == s) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic hazard_model();
        logic [4:0] prod[$];
`ifdef HAZARD_FWD_EN
        if (ex_mem_read && ex_rd != 0) prod.push_back(ex_rd);
`else
        if (ex_we) prod.push_back(ex_rd);
        if (mem_we) prod.push_back(mem_rd);
        if (wb_we) prod.push_back(wb_rd);
`endif
        foreach (prod[i])
            if ((id_rs1 != 0 && prod[i] == id_rs1) || (id_rs2 != 0 && prod[i] == id_rs2)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic sample();
        @(negedge clk);
        mw = mem_req && !dmem_ack;
        hz = hazard_model();
        dstall = (!m_act && div_start) || (m_act && m_age <= DL - 2);
        e_done = m_act && m_age >= DL - 1 && !mw;
        e_fd = pc_src && !mw && !(m_act && m_age <= DL - 1);
        e_sf = mw || dstall || (hz && !e_fd);
        e_se = mw || dstall;
        e_fe = hz || e_fd;
        e_fm = dstall;
`ifdef HAZARD_FWD_EN
        e_fa = fwd_model(ex_rs1);
        e_fb = fwd_model(ex_rs2);
`else
        e_fa = 2'b00;
        e_fb = 2'b00;
`endif
        chk("stall_f", 32'(stall_f), 32'(e_sf));
        chk("stall_d", 32'(stall_d), 32'(e_sf));
        chk("stall_e", 32'(stall_e), 32'(e_se));
        chk("stall_m", 32'(stall_m), 32'(mw));
        chk("flush_d", 32'(flush_d), 32'(e_fd));
        chk("flush_e", 32'(flush_e), 32'(e_fe));
        chk("flush_m", 32'(flush_m), 32'(e_fm));
        chk("flush_w", 32'(flush_w), 32'(mw));
        chk("fwd_a", 32'(fwd_a), 32'(e_fa));
        chk("fwd_b", 32'(fwd_b), 32'(e_fb));
        chk("div_done", 32'(div_done), 32'(e_done));
        chk("busy", 32'(busy), 32'(m_act));
        chk("stall_cnt", stall_cnt, m_cnt);
    endtask

    task automatic advance();
        @(posedge clk);
        if (m_act) begin
            if (e_done) m_act = 0;
            else m_age++;
        end else if (div_start) begin
            m_act = 1;
            m_age = 1;
        end
        m_cnt += 32'(e_sf);
        #1;
        cyc++;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    task automatic do_reset(input bit check_now);
        idle();
        rst_n = 0;
        #1;
        if (check_now) begin
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(div_done), 32'd0);
            chk("rst_cnt", stall_cnt, 32'd0);
            chk("rst_stall", 32'(stall_f), 32'd0);
        end
        m_act = 0;
        m_cnt = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        cyc = 0;
    endtask

    initial begin
        do_reset(0);
        // forwarding / RAW: x5 in MEM and WB, x5 as EX rs1 and ID rs1
        idle();
        {mem_rd, mem_we, wb_rd, wb_we, ex_rs1, id_rs1} = {5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 5'd5};
        sample();
`ifdef HAZARD_FWD_EN
        chk("s1_fwd_a", 32'(fwd_a), 32'd2);
`else
        chk("s1_stall_f", 32'(stall_f), 32'd1);
`endif
        advance();
        // load-use on x7, then it resolves after one cycle
        idle();
        {ex_mem_read, ex_we, ex_rd, id_rs2} = {1'b1, 1'b1, 5'd7, 5'd7};
        sample();
        chk("s2_stall_f", 32'(stall_f), 32'd1);
        chk("s2_stall_d", 32'(stall_d), 32'd1);
        chk("s2_flush_e", 32'(flush_e), 32'd1);
        advance();
        idle();
        id_rs2 = 5'd7;
        sample();
        chk("s2_released", 32'(stall_f), 32'd0);
        advance();
        idle();
        {ex_mem_read, ex_we, ex_rd, id_rs2} = {1'b1, 1'b1, 5'd0, 5'd0};
        sample();
        chk("s2_x0_nostall", 32'(stall_f), 32'd0);
        advance();
        // divide at cycle 10 with no memory wait
        do_reset(0);
        for (int c = 0; c <= 18; c++) begin
            idle();
            div_start = (c == 10);
            sample();
            if (c >= 10 && c <= 16) chk("s3_stall", 32'({stall_f, flush_m}), 32'd3);
            if (c == 16) chk("s3_done16", 32'(div_done), 32'd0);
            if (c == 17) chk("s3_done17", 32'({div_done, stall_f}), 32'd2);
            if (c == 18) chk("s3_cnt", stall_cnt, 32'd7);
            if (c == 18) chk("s3_idle", 32'(busy), 32'd0);
            advance();
        end
        // divide at cycle 10 with memory wait during 15..19
        do_reset(0);
        for (int c = 0; c <= 21; c++) begin
            idle();
            div_start = (c == 10) || (c == 14);
            mem_req = (c >= 15 && c <= 19);
            sample();
            if (c >= 15 && c <= 19) chk("s4_mwait", 32'({stall_m, flush_w}), 32'd3);
            if (c >= 17 && c <= 19) chk("s4_nodone", 32'(div_done), 32'd0);
            if (c == 18) chk("s4_busy", 32'(busy), 32'd1);
            if (c == 20) chk("s4_done20", 32'(div_done), 32'd1);
            if (c == 21) chk("s4_cnt", stall_cnt, 32'd10);
            advance();
        end
        // branch versus load-use, and branch deferred by a memory wait
        idle();
        {ex_mem_read, ex_we, ex_rd, id_rs2, pc_src} = {1'b1, 1'b1, 5'd7, 5'd7, 1'b1};
        sample();
        chk("s5_flush", 32'({flush_d, flush_e, stall_f, stall_d}), 32'hC);
        advance();
        idle();
        {pc_src, mem_req} = 2'b11;
        sample();
        chk("s5_deferred", 32'({flush_d, stall_f}), 32'd1);
        advance();
        dmem_ack = 1;
        sample();
        chk("s5_released", 32'(flush_d), 32'd1);
        advance();
        // reset in the middle of a divide
        do_reset(0);
        for (int c = 0; c < 3; c++) begin
            idle();
            div_start = (c == 0);
            step();
        end
        do_reset(1);
        for (int c = 0; c < 12; c++) begin
            idle();
            sample();
            chk("s6_no_done", 32'({div_done, busy}), 32'd0);
            advance();
        end
        // random traffic
        for (int c = 0; c < 400; c++) begin
            id_rs1 = 5'($urandom_range(0, 7));
            id_rs2 = 5'($urandom_range(0, 7));
            ex_rs1 = 5'($urandom_range(0, 7));
            ex_rs2 = 5'($urandom_range(0, 7));
            ex_rd = 5'($urandom_range(0, 7));
            mem_rd = 5'($urandom_range(0, 7));
            wb_rd = 5'($urandom_range(0, 7));
            ex_we = 1'($urandom_range(0, 1));
            mem_we = 1'($urandom_range(0, 1));
            wb_we = 1'($urandom_range(0, 1));
            ex_mem_read = ($urandom_range(0, 2) == 0);
            div_start = ($urandom_range(0, 9) == 0);
            mem_req = ($urandom_range(0, 3) == 0);
            dmem_ack = ($urandom_range(0, 2) != 0);
            pc_src = ($urandom_range(0, 5) == 0);
            step();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The module SHALL expose the following parameters, one per line as name, default, meaning:
- NUM_REGS, 32, architectural register count; register 0 is hardwired zero.
- ADDR_W, 5, register address width; SHALL equal clog2(NUM_REGS).
- DIV_LAT, 8, cycles a divide occupies EX; legal range 2..64.
- CNT_W, 32, width of the stall performance counter.

REQ-002 The module SHALL expose the following ports, one per line as name, direction, width, meaning:
- clk_i, in, 1, the single clock.
- rst_ni, in, 1, asynchronous active-low reset.
- id_rs1_addr_i, in, ADDR_W, ID-stage source 1.
- id_rs2_addr_i, in, ADDR_W, ID-stage source 2.
- ex_rs1_addr_i, in, ADDR_W, EX-stage source 1.
- ex_rs2_addr_i, in, ADDR_W, EX-stage source 2.
- ex_rd_addr_i, in, ADDR_W, EX-stage destination.
- ex_reg_we_i, in, 1, EX instruction writes rd.
- ex_mem_read_i, in, 1, EX instruction is a load.
- ex_div_start_i, in, 1, EX instruction is a divide or remainder.
- mem_rd_addr_i, in, ADDR_W, MEM-stage destination.
- mem_reg_we_i, in, 1, MEM instruction writes rd.
- mem_req_i, in, 1, MEM instruction is a load or store.
- dmem_ack_i, in, 1, data memory completes the access this cycle.
- wb_rd_addr_i, in, ADDR_W, WB-stage destination.
- wb_reg_we_i, in, 1, WB instruction writes rd.
- pc_src_e_i, in, 1, branch or jump taken in EX.
- stall_f_o, out, 1, hold PC.
- stall_d_o, out, 1, hold IF/ID.
- stall_e_o, out, 1, hold ID/EX.
- stall_m_o, out, 1, hold EX/MEM.
- flush_d_o, out, 1, clear IF/ID.
- flush_e_o, out, 1, clear ID/EX.
- flush_m_o, out, 1, bubble into EX/MEM.
- flush_w_o, out, 1, bubble into MEM/WB.
- fwd_a_o, out, 2, rs1 forward select: 00 = register file, 01 = WB, 10 = MEM.
- fwd_b_o, out, 2, rs2 forward select, same encoding as fwd_a_o.
- div_done_o, out, 1, divide result valid in EX this cycle.
- busy_o, out, 1, FSM not in IDLE.
- stall_cnt_o, out, CNT_W, count of cycles with stall_f_o high.

REQ-003 The design SHALL use one clock, clk_i, and an asynchronous active-low reset, rst_ni.

Function
REQ-004 The module SHALL define mem_wait = mem_req_i && !dmem_ack_i.
- While mem_wait is high: stall_f_o, stall_d_o, stall_e_o and stall_m_o SHALL be 1.
- While mem_wait is high: flush_w_o SHALL be 1.
REQ-005 The module SHALL define lw_stall = ex_mem_read_i && ex_rd_addr_i != 0 && ex_rd_addr_i matches id_rs1_addr_i or id_rs2_addr_i.
- lw_stall SHALL drive stall_f_o, stall_d_o and flush_e_o.
REQ-006 The FSM SHALL have three states: IDLE, DIV_BUSY and DIV_DONE.
- IDLE -> DIV_BUSY on ex_div_start_i; the down-counter loads DIV_LAT-2.
- DIV_BUSY decrements the counter each cycle, regardless of mem_wait.
- DIV_BUSY -> DIV_DONE when the counter is 0 and mem_wait is high.
- DIV_BUSY -> IDLE when the counter is 0 and mem_wait is low.
- DIV_DONE -> IDLE on the first cycle mem_wait is low.
REQ-007 Divide stall timing:
- stall_f_o, stall_d_o and stall_e_o SHALL be 1 and flush_m_o SHALL be 1 in the cycle ex_div_start_i is seen in IDLE.
- The same outputs SHALL stay asserted in every DIV_BUSY cycle with a nonzero counter.
- A divide starting in cycle t SHALL therefore stall cycles t..t+DIV_LAT-2.
REQ-008 div_done_o SHALL be 1 for exactly one cycle: the final divide cycle with mem_wait low. This is t+DIV_LAT-1 when there is no memory wait.
REQ-009 ex_div_start_i SHALL be ignored outside IDLE.
REQ-010 flush_d_o SHALL equal pc_src_e_i && !mem_wait && FSM not DIV_BUSY.
- flush_e_o SHALL be 1 whenever flush_d_o is 1.
- The flush SHALL take priority over lw_stall: when both occur, stall_f_o and stall_d_o SHALL be 0 and flush_e_o SHALL be 1.
REQ-011 fwd_a_o and fwd_b_o SHALL be combinational:
- MEM match (mem_reg_we_i, rd != 0, rd equals the EX source) selects 10.
- Otherwise a WB match selects 01.
- Otherwise the select is 00.
- MEM takes priority over WB.
REQ-012 stall_cnt_o SHALL increment by 1 each cycle stall_f_o is 1 and SHALL wrap modulo 2^CNT_W.
REQ-013 busy_o SHALL be 1 in DIV_BUSY and DIV_DONE.

Reset
REQ-014 Asserting rst_ni low SHALL immediately, and asynchronously, force:
- FSM to IDLE and counter to 0.
- stall_cnt_o to 0.
- div_done_o and busy_o to 0.
REQ-015 Reset applied mid-divide SHALL abandon the divide; no div_done_o pulse SHALL follow.
REQ-016 While in reset, combinational outputs SHALL reflect the IDLE state only.

Configuration
REQ-017 With macro HAZARD_FWD_EN defined, forwarding SHALL operate per REQ-011.
REQ-018 With HAZARD_FWD_EN undefined:
- fwd_a_o and fwd_b_o SHALL be tied to 00.
- lw_stall SHALL be replaced by raw_stall, which stalls F and D and flushes E whenever any ID source (nonzero) matches a writing EX, MEM or WB destination.

Verification
REQ-019 The bench SHALL cover these scenarios:
- ADD x5 in MEM and x5 as EX rs1, with x5 also in WB -> fwd_a_o = 10 (forwarding on); stall_f_o = 1 (forwarding off).
- Load to x7 in EX, ID rs2 = x7 -> stall_f_o = 1, stall_d_o = 1 and flush_e_o = 1 for exactly one cycle; a load to x0 gives no stall.
- DIV_LAT = 8, ex_div_start_i pulsed at cycle 10 -> stalls cycles 10..16, div_done_o at 17, stall_cnt_o = 7.
- Divide with dmem_ack_i low during cycles 15..19 -> FSM passes DIV_DONE, div_done_o at 20, stall_m_o = 1 and flush_w_o = 1 in cycles 15..19.
- pc_src_e_i together with lw_stall -> flush_d_o = 1, flush_e_o = 1, stall_f_o = 0; pc_src_e_i while mem_wait -> flush deferred until dmem_ack_i.
- rst_ni low at cycle 3 of a divide -> busy_o = 0 immediately, no div_done_o afterwards, stall_cnt_o = 0.
